// File: rtl/multiplexer.sv
// multiplexer: registered bus source selector for the core datapath.
// Routes one of nine register/memory sources onto busOut, one cycle after
// the select is sampled. Optional build macro MULTIPLEXER_HOLD_ON_IDLE_EN
// makes idle/unused select codes hold busOut instead of clearing it.

package details;

  // Control-unit select codes; 10..15 are unused and behave like idle.
  typedef enum logic [3:0] {
    DMem_sel = 4'd0,
    R_sel    = 4'd1,
    IR_sel   = 4'd2,
    RL_sel   = 4'd3,
    RC_sel   = 4'd4,
    RP_sel   = 4'd5,
    RQ_sel   = 4'd6,
    R1_sel   = 4'd7,
    AC_sel   = 4'd8,
    idle     = 4'd9
  } bus_in_sel_t;

endpackage : details

module multiplexer #(
  parameter int WIDTH    = 12,
  parameter int IR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  details::bus_in_sel_t selectIn,
  input  logic [WIDTH-1:0]     DMem,
  input  logic [WIDTH-1:0]     R,
  input  logic [IR_WIDTH-1:0]  IR,
  input  logic [WIDTH-1:0]     RL,
  input  logic [WIDTH-1:0]     RC,
  input  logic [WIDTH-1:0]     RP,
  input  logic [WIDTH-1:0]     RQ,
  input  logic [WIDTH-1:0]     R1,
  input  logic [WIDTH-1:0]     AC,
  output logic [WIDTH-1:0]     busOut
);

  import details::*;

  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] bus_d;
  logic [WIDTH-1:0] ir_ext;

  // Zero-extend the instruction register to the bus width.
  always_comb begin
    ir_ext                 = '0;
    ir_ext[IR_WIDTH-1:0]   = IR;
  end

  // Next-value mux: pick the addressed source, or the idle value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
`ifdef MULTIPLEXER_HOLD_ON_IDLE_EN
    bus_d = bus_q;
`else
    bus_d = '0;
`endif
    // An X/Z select matches no item and falls to the idle default.
    case (selectIn)
      DMem_sel: bus_d = DMem;
      R_sel:    bus_d = R;
      IR_sel:   bus_d = ir_ext;
      RL_sel:   bus_d = RL;
      RC_sel:   bus_d = RC;
      RP_sel:   bus_d = RP;
      RQ_sel:   bus_d = RQ;
      R1_sel:   bus_d = R1;
      AC_sel:   bus_d = AC;
      default:  ; // idle and unused codes keep the default above
    endcase
  end

  // Output register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_d;
    end
  end

  assign busOut = bus_q;

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// tb_multiplexer: self-checking bench for the multiplexer bus selector.
// Expected values come from a source-table reference model with a one-entry
// history for the idle behaviour (hold or clear, matching the build macro).

module tb_multiplexer;

  import details::*;

  localparam int W   = 12;
  localparam int IRW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  bus_in_sel_t      sel;
  logic [W-1:0]     dmem, r, rl, rc, rp, rq, r1, ac;
  logic [IRW-1:0]   ir;
  logic [W-1:0]     bus_out;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q = '0;

  multiplexer #(.WIDTH(W), .IR_WIDTH(IRW)) dut (
    .clk      (clk),
    .rst      (rst),
    .selectIn (sel),
    .DMem     (dmem),
    .R        (r),
    .IR       (ir),
    .RL       (rl),
    .RC       (rc),
    .RP       (rp),
    .RQ       (rq),
    .R1       (r1),
    .AC       (ac),
    .busOut   (bus_out)
  );

  always #5 clk = ~clk;

  // Reference: the bus takes the addressed source; codes >= 9 park the bus.
  function automatic logic [W-1:0] ref_next(input int code, input logic [W-1:0] prev);
    logic [W-1:0] src [9];
    logic [W-1:0] ir_wide;
    ir_wide = '0;
    ir_wide[IRW-1:0] = ir;
    src = '{dmem, r, ir_wide, rl, rc, rp, rq, r1, ac};
    if (code >= 0 && code < 9) return src[code];
`ifdef MULTIPLEXER_HOLD_ON_IDLE_EN
    return prev;
`else
    return '0;
`endif
  endfunction

  task automatic set_plan_values();
    dmem = 12'd10; r = 12'd11; rl = 12'd12; rc = 12'd13; rp = 12'd14;
    rq = 12'd15; r1 = 12'd16; ac = 12'd17; ir = 8'd18;
  endtask

  // Apply a select now (just after an edge), predict, and advance one edge.
  task automatic step(input int code);
    logic [3:0] c4;
    c4 = code[3:0];
    sel = bus_in_sel_t'(c4);
    exp_q = ref_next(code, exp_q);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_plan_values();
    sel = AC_sel;
    #2 rst = 1'b1;
    exp_q = '0;
    #1;
    total++;
    if (bus_out !== 12'd0) $display("FAIL reset_async busOut=%0d expected=0", bus_out);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus_out !== 12'd0) $display("FAIL reset_hold busOut=%0d expected=0", bus_out);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus_out !== 12'd0) $display("FAIL reset_release_pre_edge busOut=%0d expected=0", bus_out);
    else passed++;
    exp_q = ref_next(int'(AC_sel), exp_q);
    @(posedge clk); #1;
    total++;
    if (bus_out !== exp_q || bus_out !== 12'd17)
      $display("FAIL reset_first_load busOut=%0d expected=17", bus_out);
    else passed++;

    // Mid-stream reset: pending R selection is dropped, nothing leaks after.
    sel = R_sel;
    #2 rst = 1'b1;
    exp_q = '0;
    #1;
    total++;
    if (bus_out !== 12'd0) $display("FAIL reset_midstream busOut=%0d expected=0", bus_out);
    else passed++;
    @(posedge clk); #1;
    sel = RQ_sel;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus_out !== 12'd0) $display("FAIL reset_no_residual busOut=%0d expected=0", bus_out);
    else passed++;
    exp_q = ref_next(int'(RQ_sel), exp_q);
    @(posedge clk); #1;
    total++;
    if (bus_out !== exp_q) $display("FAIL reset_resume busOut=%0d expected=%0d", bus_out, exp_q);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [W-1:0] plan [10];
    set_plan_values();
`ifdef MULTIPLEXER_HOLD_ON_IDLE_EN
    plan = '{12'd10, 12'd11, 12'd18, 12'd12, 12'd13, 12'd14, 12'd15, 12'd16, 12'd17, 12'd17};
`else
    plan = '{12'd10, 12'd11, 12'd18, 12'd12, 12'd13, 12'd14, 12'd15, 12'd16, 12'd17, 12'd0};
`endif
    for (int c = 0; c < 10; c++) begin
      step(c);
      total++;
      if (bus_out !== exp_q || bus_out !== plan[c])
        $display("FAIL sweep_sel%0d busOut=%0d expected=%0d", c, bus_out, plan[c]);
      else passed++;
    end
  endtask

  task automatic test_ir_extend();
    set_plan_values();
    ir = 8'hFF;
    step(int'(IR_sel));
    total++;
    if (bus_out !== 12'h0FF || bus_out !== exp_q)
      $display("FAIL ir_zero_extend busOut=%h expected=0ff", bus_out);
    else passed++;
    set_plan_values();
  endtask

  task automatic test_unused();
    logic [W-1:0] want;
    set_plan_values();
    step(int'(AC_sel));
    total++;
    if (bus_out !== 12'd17) $display("FAIL unused_pre busOut=%0d expected=17", bus_out);
    else passed++;
`ifdef MULTIPLEXER_HOLD_ON_IDLE_EN
    want = 12'd17;
`else
    want = 12'd0;
`endif
    for (int c = 10; c < 16; c++) begin
      step(c);
      total++;
      if (bus_out !== want || bus_out !== exp_q)
        $display("FAIL unused_code%0d busOut=%0d expected=%0d", c, bus_out, want);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    set_plan_values();
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? int'(R_sel) : int'(RQ_sel));
      total++;
      if (bus_out !== ((i % 2 == 0) ? 12'd11 : 12'd15) || bus_out !== exp_q)
        $display("FAIL b2b_cycle%0d busOut=%0d expected=%0d", i, bus_out, exp_q);
      else passed++;
    end
  endtask

  task automatic test_random();
    int code;
    logic [3:0] c4;
    for (int i = 0; i < 60; i++) begin
      code = int'($urandom_range(0, 15));
      c4 = code[3:0];
      sel = bus_in_sel_t'(c4);
      dmem = W'($urandom); r = W'($urandom); rl = W'($urandom); rc = W'($urandom);
      rp = W'($urandom); rq = W'($urandom); r1 = W'($urandom); ac = W'($urandom);
      ir = IRW'($urandom);
      // Late data change in the same cycle: the value at the edge wins.
      #3;
      if (i % 3 == 0) begin
        dmem = W'($urandom); r = W'($urandom); ac = W'($urandom); ir = IRW'($urandom);
      end
      exp_q = ref_next(code, exp_q);
      @(posedge clk); #1;
      total++;
      if (bus_out !== exp_q)
        $display("FAIL random_%0d sel=%0d busOut=%h expected=%h", i, code, bus_out, exp_q);
      else passed++;
    end
  endtask

  initial begin
    set_plan_values();
    sel = idle;
    test_reset();
    test_sweep();
    test_ir_extend();
    test_unused();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_multiplexer

// File: doc/multiplexer.md
# multiplexer

Bus source selector for the processor core datapath. Each cycle it routes one of nine register or memory sources onto the shared `busOut` bus, as chosen by the control unit's `selectIn` code. The output is registered on the core clock and cleared by reset. It sits between the core's register file, data memory read port and instruction register on one side and the shared bus on the other.

## Interface
Parameters:
- `WIDTH`, 12, data bus width in bits; applies to all data sources and `busOut`.
- `IR_WIDTH`, 8, instruction register width in bits; must be ≤ `WIDTH`.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-high, `rst`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `selectIn`  in  4 (`bus_in_sel_t` from package `details`)  source select.
- `DMem`  in  WIDTH  data memory read data.
- `R`  in  WIDTH  general register R.
- `IR`  in  IR_WIDTH  instruction register.
- `RL`, `RC`, `RP`, `RQ`, `R1`, `AC`  in  WIDTH each  core registers.
- `busOut`  out  WIDTH  registered bus value.

## Operation
- Select encodings:
  - DMem_sel = 0 → `DMem`
  - R_sel = 1 → `R`
  - IR_sel = 2 → `IR`, zero-extended to WIDTH (upper WIDTH−IR_WIDTH bits are 0)
  - RL_sel = 3 → `RL`
  - RC_sel = 4 → `RC`
  - RP_sel = 5 → `RP`
  - RQ_sel = 6 → `RQ`
  - R1_sel = 7 → `R1`
  - AC_sel = 8 → `AC`
  - idle = 9 → no source
- Codes 10–15 are unused and behave exactly like idle.
- Idle/unused code behaviour depends on configuration (see Configuration). Default behaviour: the next value is 0.
- The select decode is fully combinational: one next-value mux, then the output register. No other state.
- If `selectIn` is X or Z, the behaviour is that of idle. Simulation must not propagate X from a valid code.

## Timing
- Reset: `busOut` = 0 immediately on `rst` rising. It holds 0 while `rst` = 1, regardless of the select and data inputs.
- Latency: `selectIn` and the data inputs are sampled on the rising edge of `clk`. `busOut` reflects them after that edge (1-cycle latency).
- Throughput: a new selection is accepted every cycle. There is no handshake.
- Reset released between edges: the first rising edge after deassertion loads the selected source.
- Reset asserted mid-stream: the pending selection is discarded. No residual value appears after release.
- A data input changing in the same cycle as `selectIn`: the value present at the edge is captured.

## Configuration
- `MULTIPLEXER_HOLD_ON_IDLE_EN`:
  - When defined: idle and unused codes hold the previous `busOut` (register not updated). This allows the bus to be parked without a redundant select.
  - When undefined: idle and unused codes load 0.
  - Reset value is 0 in both builds.

## Test plan
All scenarios use WIDTH=12, IR_WIDTH=8, DMem=10, R=11, RL=12, RC=13, RP=14, RQ=15, R1=16, AC=17, IR=18.
- Reset: assert `rst` mid-cycle with AC_sel applied → `busOut`=0 immediately. Release `rst` → `busOut`=17 after the next edge.
- Sweep: drive selectIn 0..9 on successive edges → `busOut` = 10, 11, 18, 12, 13, 14, 15, 16, 17, then idle (0 without the macro, 17 held with it), each one edge after its select.
- IR zero-extension: set IR=8'hFF, select IR_sel → `busOut`=12'h0FF.
- Unused codes: select AC_sel then code 12 → `busOut`=17, then 0 (held at 17 when `MULTIPLEXER_HOLD_ON_IDLE_EN` is defined).
- Back-to-back changes: alternate R_sel and RQ_sel every cycle → `busOut` alternates 11/15 with no bubble.
- Random: 10+ random 4-bit selects → `busOut` matches a reference model one cycle later.
